// File: rtl/sqrt_arbiter_if.sv
// sqrt_arbiter_if: requester bus plus shared sqrt-core handshake for sqrt_arbiter
interface sqrt_arbiter_if #(
   parameter int NPORT = 4,
   parameter int W     = 8
);
   logic [NPORT-1:0]         req_i;
   logic [NPORT*W-1:0]       x_bi;
   logic [NPORT-1:0]         ready_o;
   logic [NPORT-1:0]         done_o;
   logic [W-1:0]             y_bo;
   logic [$clog2(NPORT)-1:0] grant_bo;
   logic                     busy_o;
   logic                     sq_start_o;
   logic [W-1:0]             sq_x_bo;
   logic                     sq_busy_i;
   logic [W-1:0]             sq_y_bi;
   modport master (
      output req_i, x_bi, sq_busy_i, sq_y_bi,
      input  ready_o, done_o, y_bo, grant_bo, busy_o, sq_start_o, sq_x_bo
   );
   modport slave (
      input  req_i, x_bi, sq_busy_i, sq_y_bi,
      output ready_o, done_o, y_bo, grant_bo, busy_o, sq_start_o, sq_x_bo
   );
endinterface

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one sqrt core among NPORT pulse-driven requesters
module sqrt_arbiter #(
   parameter int NPORT = 4,
   parameter int W     = 8
) (
   input logic            clk_i,
   input logic            rst_i,
   sqrt_arbiter_if.slave  bus
);
   localparam int PW = $clog2(NPORT);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
   state_t           state;
   logic [NPORT-1:0] pending;
   logic [NPORT-1:0] done;
   logic [W-1:0]     hold [NPORT];
   logic [PW-1:0]    last_grant;
   logic [PW-1:0]    grant;
   logic [PW-1:0]    sel;
   logic [W-1:0]     y;
   logic [W-1:0]     sq_x;
   logic             busy;
   logic             sq_start;
   logic [2:0]       tmo;
   // descending scan so the last hit is the first pending port after last_grant
   always_comb begin
      sel = last_grant;
      for (int i = NPORT; i >= 1; i--)
         if (pending[PW'((int'(last_grant) + i) % NPORT)]) sel = PW'((int'(last_grant) + i) % NPORT);
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         pending    <= '0;
         for (int k = 0; k < NPORT; k++) hold[k] <= '0;
         last_grant <= PW'(NPORT - 1);
         grant      <= '0;
         y          <= '0;
         sq_x       <= '0;
         sq_start   <= 1'b0;
         done       <= '0;
         busy       <= 1'b0;
         tmo        <= '0;
      end else begin
         for (int k = 0; k < NPORT; k++)
            if (bus.req_i[k] && !pending[k]) begin
               pending[k] <= 1'b1;
               hold[k]    <= bus.x_bi[k*W +: W];
            end
         case (state)
            IDLE: if (|pending) begin
               grant    <= sel;
               sq_x     <= hold[sel];
               sq_start <= 1'b1;
               busy     <= 1'b1;
               state    <= ISSUE;
            end
            ISSUE: begin
               sq_start <= 1'b0;
               tmo      <= bus.sq_busy_i ? 3'd0 : 3'd1;
               state    <= WAIT_BUSY;
            end
            // the ISSUE cycle counts toward the 8 idle-busy cycles
            WAIT_BUSY: begin
               tmo <= tmo + 3'd1;
               if (bus.sq_busy_i || tmo == 3'd7) state <= WAIT_DONE;
            end
            WAIT_DONE: if (!bus.sq_busy_i) begin
               y     <= bus.sq_y_bi;
               done  <= NPORT'(1) << grant;
               state <= RESP;
            end
            RESP: begin
               done           <= '0;
               pending[grant] <= 1'b0;
               last_grant     <= grant;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.ready_o    = ~pending;
   assign bus.done_o     = done;
   assign bus.y_bo       = y;
   assign bus.grant_bo   = grant;
   assign bus.busy_o     = busy;
   assign bus.sq_start_o = sq_start;
   assign bus.sq_x_bo    = sq_x;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed and random requests checked against a transaction-level model
module tb_sqrt_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   sqrt_arbiter_if #(.NPORT(4), .W(8)) bus ();
   sqrt_arbiter #(.NPORT(4), .W(8)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
   int n_cmp = 0, n_bad = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic [3:0] m_pend, prev_pend;
   logic [7:0] m_op [4];
   int  m_last, m_y, cur_port, start_cyc, done_cyc, n_start;
   bit  inflight, b2b, nobusy;
   int  log_port [$];
   int  log_y [$];
   task automatic check(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask
   function automatic int isqrt(input int x);
      int r = 0;
      for (int i = 0; i <= 16; i++) if (i * i <= x) r = i;
      return r;
   endfunction
   function automatic int rr_pick(input logic [3:0] p, input int last);
      for (int i = 1; i <= 4; i++) if (p[(last + i) % 4]) return (last + i) % 4;
      return -1;
   endfunction
   // core model: busy for 2..5 cycles after a start, or silent with y = 3
   initial begin
      bus.sq_busy_i = 1'b0;
      bus.sq_y_bi = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.sq_start_o) begin
            bus.sq_y_bi = nobusy ? 8'd3 : 8'(isqrt(int'(bus.sq_x_bo)));
            if (!nobusy) begin
               bus.sq_busy_i = 1'b1;
               repeat ($urandom_range(5, 2)) @(posedge clk);
               #1;
               bus.sq_busy_i = 1'b0;
            end
         end
      end
   end
   task automatic step(input logic [3:0] r, input logic [31:0] x);
      logic [3:0] cur, exp_rdy, exp_d;
      int clr = -1;
      @(negedge clk);
      cur = m_pend;
      exp_rdy = ~m_pend;
      check("ready", bus.ready_o, exp_rdy);
      if (rst_n && bus.sq_start_o) begin
         cur_port = rr_pick(prev_pend, m_last);
         if (cur_port < 0) check("start_without_request", 1, 0);
         else begin
            check("grant", bus.grant_bo, cur_port);
            check("sq_x", bus.sq_x_bo, m_op[cur_port]);
            check("busy", bus.busy_o, 1);
            if (b2b) check("b2b_gap", cyc - done_cyc, 2);
            b2b = 0;
            inflight = 1;
            start_cyc = cyc;
            n_start++;
         end
      end
      if (bus.done_o != 0) begin
         if (!inflight) check("spurious_done", bus.done_o, 0);
         else begin
            exp_d = 4'b1 << cur_port;
            m_y = nobusy ? 3 : isqrt(int'(m_op[cur_port]));
            check("done", bus.done_o, exp_d);
            check("y", bus.y_bo, m_y);
            check("grant_at_done", bus.grant_bo, cur_port);
            if (nobusy) check("timeout_latency", cyc - start_cyc, 9);
            log_port.push_back(cur_port);
            log_y.push_back(m_y);
            done_cyc = cyc;
            inflight = 0;
            clr = cur_port;
         end
      end else check("y_hold", bus.y_bo, m_y);
      prev_pend = cur;
      bus.req_i = r;
      bus.x_bi = x;
      if (rst_n)
         for (int k = 0; k < 4; k++)
            if (r[k] && !m_pend[k]) begin
               m_pend[k] = 1'b1;
               m_op[k] = x[8*k +: 8];
            end
      if (clr >= 0) begin
         m_pend[clr] = 1'b0;
         m_last = clr;
         b2b = m_pend != 0;
      end
   endtask
   task automatic chk_reset();
      check("rst_ready", bus.ready_o, 15);
      check("rst_done", bus.done_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_y", bus.y_bo, 0);
      check("rst_grant", bus.grant_bo, 0);
      check("rst_sq_x", bus.sq_x_bo, 0);
      check("rst_sq_start", bus.sq_start_o, 0);
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 chk_reset();
      m_pend = '0;
      prev_pend = '0;
      m_last = 3;
      m_y = 0;
      inflight = 0;
      b2b = 0;
      bus.req_i = '0;
      repeat (6) step(4'b0, 32'b0);
      rst_n = 1'b1;
   endtask
   task automatic drain();
      int n = 0;
      while ((m_pend != 0 || inflight) && n < 300) begin
         step(4'b0, 32'b0);
         n++;
      end
      check("drain_timeout", m_pend != 0 || inflight, 0);
      step(4'b0, 32'b0);
   endtask
   task automatic clear_log();
      log_port.delete();
      log_y.delete();
      n_start = 0;
   endtask
   initial begin
      int n;
      int exp_y [4] = '{0, 1, 7, 15};
      bus.req_i = '0;
      bus.x_bi = '0;
      nobusy = 0;
      for (int k = 0; k < 4; k++) m_op[k] = '0;
      #1 rst_n = 1'b0;
      do_reset();
      clear_log();
      step(4'b0100, 32'(100) << 16);
      drain();
      check("single_count", log_port.size(), 1);
      check("single_port", log_port[0], 2);
      check("single_y", log_y[0], 10);
      check("single_starts", n_start, 1);
      check("single_grant", bus.grant_bo, 2);
      do_reset();
      clear_log();
      step(4'b1111, {8'd225, 8'd49, 8'd1, 8'd0});
      drain();
      check("simul_count", log_port.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("simul_port", log_port[i], i);
         check("simul_y", log_y[i], exp_y[i]);
      end
      clear_log();
      step(4'b0010, 32'(9) << 8);
      drain();
      step(4'b0011, {16'd0, 8'd36, 8'd4});
      drain();
      check("rr_count", log_port.size(), 3);
      check("rr_first", log_port[0], 1);
      check("rr_second", log_port[1], 0);
      check("rr_third", log_port[2], 1);
      clear_log();
      step(4'b0001, 32'd16);
      step(4'b0, 32'b0);
      step(4'b0, 32'b0);
      step(4'b0001, 32'd81);
      drain();
      check("ignored_count", log_port.size(), 1);
      check("ignored_y", log_y[0], 4);
      clear_log();
      step(4'b1000, 32'(200) << 24);
      n = 0;
      while (!(inflight && cyc == start_cyc + 2) && n < 20) begin
         step(4'b0, 32'b0);
         n++;
      end
      check("reach_wait_done", inflight && cyc == start_cyc + 2, 1);
      do_reset();
      check("reset_no_done", log_port.size(), 0);
      step(4'b0001, 32'd64);
      drain();
      check("after_reset_count", log_port.size(), 1);
      check("after_reset_y", log_y[0], 8);
      nobusy = 1;
      clear_log();
      step(4'b0100, 32'(99) << 16);
      drain();
      nobusy = 0;
      check("timeout_count", log_port.size(), 1);
      check("timeout_y", log_y[0], 3);
      repeat (400) step(4'($urandom) & 4'($urandom), $urandom);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter W, default 8, operand/result width.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_i  input  4  one-cycle request pulse per requester.
REQ-006 SHALL have port x_bi  input  32  packed operands; port k uses bits [8k+7:8k].
REQ-007 SHALL have port ready_o  output  4  bit k high means port k may issue a request.
REQ-008 SHALL have port done_o  output  4  one-cycle completion pulse for the granted port.
REQ-009 SHALL have port y_bo  output  8  result, valid during the done_o pulse and held until the next completion.
REQ-010 SHALL have port grant_bo  output  2  index of the port currently or last served.
REQ-011 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port sq_start_o  output  1  start pulse to the shared sqrt core.
REQ-013 SHALL have port sq_x_bo  output  8  operand to the sqrt core, held stable from ISSUE through WAIT_DONE.
REQ-014 SHALL have port sq_busy_i  input  1  sqrt core busy flag.
REQ-015 SHALL have port sq_y_bi  input  8  sqrt core result, valid once sq_busy_i falls.

Function
REQ-016 SHALL keep one pending bit and one 8-bit holding register per port; ready_o[k] = ~pending[k].
REQ-017 SHALL, on req_i[k] with ready_o[k] high, set pending[k] and capture x_bi slice k on the same edge.
REQ-018 SHALL ignore req_i[k] while pending[k] is set; the held operand SHALL be unchanged.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-020 IDLE: if any pending bit is set, SHALL grant the first pending port in round-robin order starting at (last_grant+1) mod 4, load its operand into sq_x_bo, update grant_bo, and go to ISSUE.
REQ-021 ISSUE: SHALL assert sq_start_o for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: SHALL go to WAIT_DONE when sq_busy_i = 1. If sq_busy_i stays 0 for 8 consecutive cycles, SHALL go to WAIT_DONE anyway, covering a core that finishes without raising busy.
REQ-023 WAIT_DONE: when sq_busy_i = 0, SHALL capture sq_y_bi into y_bo and go to RESP.
REQ-024 RESP: SHALL pulse done_o[grant] for one cycle, clear pending[grant], record last_grant = grant, and return to IDLE.
REQ-025 A req_i[k] arriving in the same cycle as done_o[k] SHALL be ignored, because ready_o[k] is still low.
REQ-026 A req_i on a non-granted port SHALL be accepted in any state; arbitration SHALL be decided only in IDLE, with no preemption.
REQ-027 Arbiter overhead per transaction SHALL be: IDLE→ISSUE 1 cycle, plus 1 ISSUE cycle, plus core time, plus 1 RESP cycle.
REQ-028 Back-to-back pending requests SHALL be served with exactly one IDLE cycle between a RESP and the next ISSUE.
REQ-029 At most one done_o bit SHALL be high in any cycle.

Reset
REQ-030 While rst_i = 0, asynchronously: FSM = IDLE; pending = 0; holding registers = 0; last_grant = 3 (so port 0 has first priority); grant_bo = 0; y_bo = 0; sq_x_bo = 0; sq_start_o = 0; done_o = 0; busy_o = 0; ready_o = 4'b1111.
REQ-031 Reset asserted mid-transaction SHALL discard all pending requests with no done_o pulse; normal operation SHALL resume on the first clock edge after rst_i returns high.

Verification
REQ-032 Single request: req_i[2] with x = 100 -> one sq_start_o pulse with sq_x_bo = 100; done_o = 4'b0100; y_bo = 10; grant_bo = 2.
REQ-033 Simultaneous requests: all four ports pulse in one cycle with x = 0, 1, 49, 225 -> done order 0, 1, 2, 3; y = 0, 1, 7, 15; exactly one IDLE cycle between transactions.
REQ-034 Round robin: port 1 served, then ports 0 and 1 re-request together -> port 0 served before port 1.
REQ-035 Ignored request: req_i[0] with x = 16 while pending[0] is set, the second pulse carrying x = 81 -> one completion only, with y_bo = 4.
REQ-036 Mid-operation reset: rst_i driven low during WAIT_DONE -> all outputs at reset values, no done_o pulse; a subsequent request with x = 64 yields y_bo = 8.
REQ-037 Busy timeout: core model never raises sq_busy_i and supplies y = 3 -> WAIT_DONE is entered 8 cycles after ISSUE; done_o pulses with y_bo = 3.
